// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI4 write-channel slave. Accepts one AW burst at a time,
// consumes its W beats, expands FIXED/INCR/WRAP addresses into a per-beat
// memory write port and returns a single B response.
// Optional macro AXI_WR_WLAST_CHK_EN: when defined, every W beat checks
// wlast against the beat count and a mismatch turns the burst into SLVERR.
module axi_wr_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_WIDTH-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);

    // Largest legal awsize: one beat may not be wider than the data bus.
    localparam int SIZE_MAX = $clog2(STRB_WIDTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [7:0]            len_q;
    logic [7:0]            beat;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err;

    logic [ADDR_WIDTH-1:0] aw_nbytes;
    logic [ADDR_WIDTH-1:0] nbytes;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  aw_len_wrap_ok;
    logic                  aw_err;
    logic                  w_hs;
    logic                  last_beat;
    logic                  wlast_bad;
    logic                  beat_err;

    assign aw_nbytes = ADDR_WIDTH'(1) << s_awsize;
    assign nbytes    = ADDR_WIDTH'(1) << size_q;

    assign aw_len_wrap_ok = (s_awlen == 8'd1) || (s_awlen == 8'd3) ||
                            (s_awlen == 8'd7) || (s_awlen == 8'd15);
    assign aw_err = (s_awburst == BURST_RSVD) ||
                    (int'(s_awsize) > SIZE_MAX) ||
                    ((s_awburst == BURST_WRAP) && !aw_len_wrap_ok);

    assign w_hs      = s_wvalid && s_wready;
    assign last_beat = (beat == len_q);

`ifdef AXI_WR_WLAST_CHK_EN
    assign wlast_bad = (s_wlast != last_beat);
`else
    logic unused_wlast;
    assign unused_wlast = s_wlast;
    assign wlast_bad    = 1'b0;
`endif

    // A wlast mismatch poisons the beat on which it is seen, not just later ones.
    assign beat_err = err || wlast_bad;

    // Address of the beat after cur_addr for the captured burst type.
    always_comb begin
        next_addr = cur_addr;
        case (burst_q)
            BURST_FIXED: next_addr = cur_addr;
            BURST_INCR:  next_addr = (cur_addr & ~(nbytes - ADDR_WIDTH'(1))) + nbytes;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + nbytes) & wrap_mask);
            default:     next_addr = cur_addr;
        endcase
    end

    // Burst FSM with registered handshakes, B response and memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_bid     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            id_q      <= '0;
            cur_addr  <= '0;
            wrap_mask <= '0;
            len_q     <= '0;
            beat      <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; this default is overridden by a later
            // assignment in the same cycle, which is what makes mem_we a 1-cycle pulse.
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    s_awready <= 1'b1;
                    if (s_awvalid && s_awready) begin
                        id_q      <= s_awid;
                        cur_addr  <= s_awaddr;
                        len_q     <= s_awlen;
                        size_q    <= s_awsize;
                        burst_q   <= s_awburst;
                        // For the legal wrap lengths (len+1 a power of two) this
                        // equals (len+1)*nbytes - 1 without a multiplier.
                        wrap_mask <= (ADDR_WIDTH'(s_awlen) << s_awsize) |
                                     (aw_nbytes - ADDR_WIDTH'(1));
                        beat      <= '0;
                        err       <= aw_err;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        mem_we    <= ~beat_err;
                        mem_addr  <= cur_addr;
                        mem_wdata <= s_wdata;
                        mem_wstrb <= s_wstrb;
                        err       <= beat_err;
                        beat      <= beat + 8'd1;
                        cur_addr  <= next_addr;
                        // The beat count, not wlast, ends the burst.
                        if (last_beat) begin
                            s_wready <= 1'b0;
                            s_bvalid <= 1'b1;
                            s_bid    <= id_q;
                            s_bresp  <= beat_err ? 2'b10 : 2'b00;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
